// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped countdown timer: bus addresses,
// CTRL bit positions, mode codes and the FSM state encoding.
package tc_pkg;

    localparam logic [1:0] TC_CTRL    = 2'd0;
    localparam logic [1:0] TC_PRESET  = 2'd1;
    localparam logic [1:0] TC_COUNT   = 2'd2;

    localparam logic [1:0] TC_ONESHOT = 2'b00;
    localparam logic [1:0] TC_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/tc_timer.sv
// Countdown timer on the MEM-stage bus: CTRL/PRESET/COUNT registers, a
// four-state count FSM and a masked interrupt request to CP0.
module tc_timer
    import tc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Addr,
    input  logic             WE,
    input  logic [31:0]      WData,
    output logic [31:0]      RData,
    output logic             IRQ,
    output tc_state_e        dbg_state
);

    tc_state_e           r_state;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [31:0]         r_preset;
    logic [31:0]         r_count;
    logic                r_irq_flag;
    logic                w_reload;

    // Modes 10 and 11 fall through to one-shot behaviour.
    assign w_reload  = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == TC_RELOAD);
    assign IRQ       = r_irq_flag & r_ctrl[CTRL_IM];
    assign dbg_state = r_state;

    always_comb begin
        RData = 32'd0;
        case (Addr)
            TC_CTRL:   RData = {{(32-CTRL_W){1'b0}}, r_ctrl};
            TC_PRESET: RData = r_preset;
            TC_COUNT:  RData = r_count;
            default:   RData = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= '0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl[CTRL_EN]) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_ctrl[CTRL_EN]) begin
                        r_state <= ST_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count    <= 32'd0;
                        r_irq_flag <= 1'b1;
                        r_state    <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (w_reload) begin
                        r_irq_flag <= 1'b0;
                        r_state    <= ST_LOAD;
                    end else begin
                        r_ctrl[CTRL_EN] <= 1'b0;
                        r_state         <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Placed after the FSM so a CPU store overrides the FSM's updates.
            if (WE) begin
                case (Addr)
                    TC_CTRL: begin
                        r_ctrl     <= WData[CTRL_W-1:0];
                        r_irq_flag <= 1'b0;
                    end
                    TC_PRESET: r_preset <= WData;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: each scenario starts from reset and compares
// COUNT, IRQ, CTRL and FSM state against hand-computed edge-by-edge values.
module tb_tc_timer;
    import tc_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        IRQ;
    tc_state_e   dbg_state;

    int n_checks;
    int n_errors;

    tc_timer dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WE        (WE),
        .WData     (WData),
        .RData     (RData),
        .IRQ       (IRQ),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        Addr  = a;
        WData = d;
        WE    = 1'b1;
        tick();
        WE    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = RData;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic [31:0] rd;
    int          exp_cnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        Addr     = 2'd0;
        WE       = 1'b0;
        WData    = 32'd0;

        // Reset state
        do_reset();
        check_eq("rst_irq", 32'(IRQ), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        bus_read(TC_CTRL, rd);   check_eq("rst_ctrl", rd, 32'd0);
        bus_read(TC_PRESET, rd); check_eq("rst_preset", rd, 32'd0);

        // One-shot, PRESET=5
        bus_write(TC_PRESET, 32'd5);
        bus_write(TC_CTRL, 32'h9);               // E0
        tick();                                  // E1
        check_eq("os_load_state", 32'(dbg_state), 32'(ST_LOAD));
        tick();                                  // E2
        bus_read(TC_COUNT, rd); check_eq("os_count_e2", rd, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            tick();                              // E(2+k)
            bus_read(TC_COUNT, rd);
            check_eq($sformatf("os_count_k%0d", k), rd, 32'(5 - k));
            check_eq($sformatf("os_irq_k%0d", k), 32'(IRQ), (k == 5) ? 32'd1 : 32'd0);
        end
        check_eq("os_int_state", 32'(dbg_state), 32'(ST_INT));
        tick();                                  // E8
        check_eq("os_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        bus_read(TC_CTRL, rd); check_eq("os_ctrl_en_clr", rd, 32'h8);
        tick();
        check_eq("os_irq_hold", 32'(IRQ), 32'd1);
        bus_read(TC_COUNT, rd); check_eq("os_count_hold0", rd, 32'd0);
        bus_write(TC_CTRL, 32'h0);
        check_eq("os_irq_clr", 32'(IRQ), 32'd0);

        // Reset drops a pending IRQ
        bus_write(TC_CTRL, 32'h9);
        for (int k = 0; k < 7; k++) tick();
        check_eq("pre_rst_irq", 32'(IRQ), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("async_rst_irq", 32'(IRQ), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Reset mid-count at COUNT=7
        bus_write(TC_PRESET, 32'd9);
        bus_write(TC_CTRL, 32'h9);
        tick(); tick(); tick(); tick();          // E4: 9,8,7
        bus_read(TC_COUNT, rd); check_eq("mid_count7", rd, 32'd7);
        reset = 1'b0;
        bus_read(TC_CTRL, rd);   check_eq("mid_rst_ctrl", rd, 32'd0);
        bus_read(TC_PRESET, rd); check_eq("mid_rst_preset", rd, 32'd0);
        bus_read(TC_COUNT, rd);  check_eq("mid_rst_count", rd, 32'd0);
        check_eq("mid_rst_irq", 32'(IRQ), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check_eq("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Auto-reload, PRESET=3: period 5, COUNT 3,2,1,0,0 from E2
        do_reset();
        bus_write(TC_PRESET, 32'd3);
        bus_write(TC_CTRL, 32'hB);               // E0
        for (int i = 1; i <= 16; i++) begin
            tick();
            bus_read(TC_COUNT, rd);
            if (i == 1) exp_cnt = 0;
            else begin
                case ((i - 2) % 5)
                    0: exp_cnt = 3;
                    1: exp_cnt = 2;
                    2: exp_cnt = 1;
                    default: exp_cnt = 0;
                endcase
            end
            check_eq($sformatf("ar_count_e%0d", i), rd, 32'(exp_cnt));
            check_eq($sformatf("ar_irq_e%0d", i), 32'(IRQ), (i % 5 == 0) ? 32'd1 : 32'd0);
        end

        // Masked expiry, PRESET=2
        do_reset();
        bus_write(TC_PRESET, 32'd2);
        bus_write(TC_CTRL, 32'h1);
        tick(); tick(); tick(); tick();          // E4: INT
        check_eq("mask_int_state", 32'(dbg_state), 32'(ST_INT));
        check_eq("mask_irq_low", 32'(IRQ), 32'd0);
        tick();
        bus_write(TC_CTRL, 32'h8);
        check_eq("mask_flag_clr", 32'(IRQ), 32'd0);
        bus_read(TC_CTRL, rd); check_eq("mask_ctrl", rd, 32'h8);

        // Pause plus PRESET write during CNT
        do_reset();
        bus_write(TC_PRESET, 32'd9);
        bus_write(TC_CTRL, 32'h9);               // E0
        tick(); tick(); tick();                  // E3: count 8
        bus_write(TC_PRESET, 32'd6);             // E4: count 7
        bus_read(TC_COUNT, rd); check_eq("pw_count_run", rd, 32'd7);
        tick(); tick();                          // E6: count 5
        bus_write(TC_CTRL, 32'h8);               // E7: count 4
        bus_read(TC_COUNT, rd); check_eq("pause_count4", rd, 32'd4);
        tick(); tick(); tick();
        bus_read(TC_COUNT, rd); check_eq("pause_hold", rd, 32'd4);
        check_eq("pause_state", 32'(dbg_state), 32'(ST_IDLE));
        bus_write(TC_CTRL, 32'h9);
        tick();
        bus_read(TC_COUNT, rd); check_eq("reen_load_pending", rd, 32'd4);
        tick();
        bus_read(TC_COUNT, rd); check_eq("reen_reload", rd, 32'd6);

        // PRESET=0 expires 3 edges after enable
        do_reset();
        bus_write(TC_CTRL, 32'h9);               // E0
        tick();
        check_eq("p0_irq_e1", 32'(IRQ), 32'd0);
        tick();
        check_eq("p0_irq_e2", 32'(IRQ), 32'd0);
        tick();
        check_eq("p0_irq_e3", 32'(IRQ), 32'd1);
        check_eq("p0_state_e3", 32'(dbg_state), 32'(ST_INT));

        // Bus decode
        do_reset();
        bus_write(TC_PRESET, 32'h1234);
        bus_write(TC_CTRL, 32'h1);               // E0
        tick(); tick();                          // E2: 0x1234
        bus_write(TC_COUNT, 32'hDEAD);           // E3: 0x1233
        bus_read(TC_COUNT, rd); check_eq("dec_count_ro", rd, 32'h1233);
        bus_write(2'd3, 32'hDEAD);               // E4: 0x1232
        bus_read(2'd3, rd); check_eq("dec_addr3", rd, 32'd0);
        bus_read(TC_COUNT, rd); check_eq("dec_count_a3", rd, 32'h1232);
        bus_read(TC_PRESET, rd); check_eq("dec_preset", rd, 32'h1234);
        bus_write(TC_CTRL, 32'hFFFF_FFFF);
        bus_read(TC_CTRL, rd); check_eq("dec_ctrl_mask", rd, 32'h0000_000F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tc_timer.md
# tc_timer

Memory-mapped countdown timer that answers the CPU's data-memory-side store and load accesses, sitting on the MEM-stage bus opposite the `DM` write/read path. It exposes three 32-bit word registers (CTRL, PRESET, COUNT) and raises `IRQ` when the count expires. `IRQ` goes to the CP0/exception logic.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `Addr` input 2: word select, driven from `EX_MEM_ALUResult[3:2]`.
  - 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `WE` input 1: word store strobe; sampled at the rising edge.
- `WData` input 32: store data.
- `RData` output 32: combinational read of the register selected by `Addr`.
- `IRQ` output 1: interrupt request, `irq_flag & CTRL.IM`.

## Operation
- CTRL register, bits [3:0] stored, bits [31:4] read as 0:
  - [0] `Enable`.
  - [2:1] `Mode`: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
  - [3] `IM` interrupt mask (1 = unmasked).
- PRESET: 32-bit read/write.
- COUNT: read-only; writes are ignored.
- Addr 3: writes are ignored; reads return 0.
- FSM states are IDLE, LOAD, CNT, INT. Transitions are evaluated on the register values present before the edge.
  - IDLE: if `Enable`, go to LOAD; otherwise stay.
  - LOAD: `COUNT <= PRESET`; go to CNT.
  - CNT, `Enable` = 0: go to IDLE; COUNT holds its value.
  - CNT, COUNT > 1: `COUNT <= COUNT-1`.
  - CNT, COUNT ≤ 1: `COUNT <= 0`; set `irq_flag`; go to INT.
  - INT, one-shot mode: clear `Enable`; go to IDLE; `irq_flag` stays set.
  - INT, auto-reload mode: clear `irq_flag`; go to LOAD.
- `irq_flag` clearing:
  - Cleared by any CPU write to CTRL.
  - Cleared in INT when the mode is auto-reload.
- Conflicts and boundary rules:
  - A CPU write to CTRL in the same cycle as INT's `Enable` clear: the CPU value wins.
  - A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
  - PRESET = 0 and PRESET = 1 both expire one edge after LOAD.
  - COUNT never underflows.
- Reset, including mid-count:
  - Outputs: `IRQ` = 0, `RData` reflects the zeroed registers.
  - State: FSM = IDLE; CTRL = PRESET = COUNT = 0; `irq_flag` = 0.

## Timing
- The register write takes effect at the edge where `WE` = 1; the read value is visible on `RData` in the following cycle.
- PRESET = N ≥ 1, CTRL write at edge E0 enabling the timer:
  - E1: state becomes LOAD.
  - E2: COUNT = N, state becomes CNT.
  - After edge E(2+k): COUNT = N-k.
  - E(N+2): COUNT = 0, state becomes INT, `IRQ` rises (if IM = 1).
- One-shot mode:
  - E(N+3): state becomes IDLE and `Enable` = 0.
  - `IRQ` stays high until a CTRL write.
- Auto-reload mode:
  - `IRQ` is high for exactly one cycle.
  - E(N+3): state becomes LOAD.
  - Expiry period is N+2 cycles.
- Clearing `Enable` during CNT at edge Et: COUNT freezes from Et+1 and the state becomes IDLE.
- Re-enabling reloads COUNT from PRESET; the count does not resume.

## Structure
- Shared package `tc_pkg` holds:
  - Address constants `TC_CTRL` = 2'd0, `TC_PRESET` = 2'd1, `TC_COUNT` = 2'd2.
  - State encoding (IDLE = 0, LOAD = 1, CNT = 2, INT = 3).
  - Mode constants `TC_ONESHOT` = 2'b00, `TC_RELOAD` = 2'b01.
  - CTRL bit indices.
- Single module with no sub-module. The FSM, the registers, and the read mux live in one file.

## Test plan
- **Reset mid-count:** assert `reset` low during CNT with COUNT = 7. Required: `IRQ` = 0 and CTRL, PRESET, COUNT all read 0 immediately; state IDLE after release.
- **One-shot:** PRESET = 5, CTRL = 4'b1001. Required:
  - COUNT reads 5, 4, 3, 2, 1, 0 on successive edges.
  - `IRQ` rises 7 edges after the CTRL write and holds.
  - CTRL reads 4'b1000.
  - Writing CTRL = 0 drops `IRQ` next cycle.
- **Auto-reload:** PRESET = 3, CTRL = 4'b1011. Required: `IRQ` 1-cycle pulses every 5 cycles; COUNT sequence 3, 2, 1, 0 repeating.
- **Mask:** PRESET = 2, CTRL = 4'b0001. Required:
  - `IRQ` stays 0 at expiry.
  - Writing CTRL = 4'b1000 clears the flag, so `IRQ` stays 0.
- **Pause and edge values:**
  - Clear `Enable` at COUNT = 4. Required: COUNT holds at 4; re-enable reloads PRESET.
  - PRESET = 0. Required: `IRQ` 3 edges after the enable write.
- **Bus decode:**
  - Write 0xDEAD to COUNT and to Addr 3. Required: COUNT unchanged; Addr 3 reads 0.
  - Write 0xFFFFFFFF to CTRL. Required: reads back 0x0000000F.
  - PRESET write during CNT. Required: applied only at the next LOAD.
